// File: rtl/cfg_pkg.sv
// Shared types and constants for the layers configuration bus master.
package cfg_pkg;

    localparam int unsigned CFG_DWIDTH_DEF = 32;
    localparam int unsigned CFG_AWIDTH_DEF = 5;

    typedef struct packed {
        logic [CFG_AWIDTH_DEF-1:0] addr;
        logic [CFG_DWIDTH_DEF-1:0] data;
        logic                      last;
    } cfg_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GAP   = 3'd2,
        ST_STALL = 3'd3,
        ST_DONE  = 3'd4
    } cfg_state_e;

    // Register map of the layers datapath, mirrored from cfg_parameters.vh.
    localparam logic [CFG_AWIDTH_DEF-1:0] CFG_REG_LAYER_TYPE  = 5'd0;
    localparam logic [CFG_AWIDTH_DEF-1:0] CFG_REG_IMG_WIDTH   = 5'd1;
    localparam logic [CFG_AWIDTH_DEF-1:0] CFG_REG_IMG_HEIGHT  = 5'd2;
    localparam logic [CFG_AWIDTH_DEF-1:0] CFG_REG_IN_CHANNELS = 5'd3;
    localparam logic [CFG_AWIDTH_DEF-1:0] CFG_REG_OUT_CHANNELS = 5'd4;
    localparam logic [CFG_AWIDTH_DEF-1:0] CFG_REG_WEIGHT_BASE = 5'd5;
    localparam logic [CFG_AWIDTH_DEF-1:0] CFG_REG_BIAS_BASE   = 5'd6;
    localparam logic [CFG_AWIDTH_DEF-1:0] CFG_REG_SHIFT       = 5'd7;

endpackage

// File: rtl/cfg_fifo.sv
// Single-clock write buffer with registered occupancy and a combinational head.
module cfg_fifo
    import cfg_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = cfg_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  entry_t                 wr_entry_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/cfg_writer.sv
// Configuration bus master: buffers host register writes and replays them as
// spaced cfg_valid strobes, starting a batch only while the datapath is idle.
module cfg_writer
    import cfg_pkg::*;
#(
    parameter int unsigned CFG_DWIDTH = CFG_DWIDTH_DEF,
    parameter int unsigned CFG_AWIDTH = CFG_AWIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CFG_DWIDTH-1:0]       host_data,
    input  logic [CFG_AWIDTH-1:0]       host_addr,
    input  logic                        host_last,
    input  logic                        host_val,
    output logic                        host_rdy,
    input  logic                        layer_busy,
    output logic [CFG_DWIDTH-1:0]       cfg_data,
    output logic [CFG_AWIDTH-1:0]       cfg_addr,
    output logic                        cfg_valid,
    output logic                        cfg_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned GCW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef struct packed {
        logic [CFG_AWIDTH-1:0] addr;
        logic [CFG_DWIDTH-1:0] data;
        logic                  last;
    } entry_t;

    entry_t          wr_entry, head;
    logic            fifo_full, fifo_empty;
    logic            push_c, pop_c;

    cfg_state_e      state_q, state_d;
    logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
    logic            last_q, last_d;
    logic            cfg_valid_q, cfg_valid_d;
    logic            cfg_done_q, cfg_done_d;
    logic [CFG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [CFG_DWIDTH-1:0] cfg_data_q, cfg_data_d;

    assign wr_entry.addr = host_addr;
    assign wr_entry.data = host_data;
    assign wr_entry.last = host_last;

    assign host_rdy = ~fifo_full & ~rst;
    assign push_c   = host_val & host_rdy;

    cfg_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_c),
        .wr_entry_i (wr_entry),
        .pop_i      (pop_c),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // In ISSUE the entry was already popped, so fifo_empty reflects the remainder.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !layer_busy) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (last_q)              state_d = ST_DONE;
                else if (GAP_CYCLES > 0) state_d = ST_GAP;
                else if (!fifo_empty)    state_d = ST_ISSUE;
                else                     state_d = ST_STALL;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d = fifo_empty ? ST_STALL : ST_ISSUE;
            end
            ST_STALL: begin
                if (!fifo_empty) state_d = ST_ISSUE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The head is captured and popped on the edge that enters ISSUE.
    always_comb begin
        pop_c       = (state_d == ST_ISSUE);
        cfg_valid_d = pop_c;
        cfg_done_d  = (state_d == ST_DONE);
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
        last_d      = last_q;
        gap_cnt_d   = GCW'(GAP_LOAD);
        if (pop_c) begin
            cfg_addr_d = head.addr;
            cfg_data_d = head.data;
            last_d     = head.last;
        end
        if (state_q == ST_GAP && gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GCW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_valid_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            last_q      <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            cfg_valid_q <= cfg_valid_d;
            cfg_done_q  <= cfg_done_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            last_q      <= last_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign cfg_valid = cfg_valid_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_data  = cfg_data_q;

endmodule

// File: tb/tb_cfg_writer.sv
// Directed bench for cfg_writer: one instance with GAP_CYCLES=1, one with 0.
module tb_cfg_writer;
    import cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] host_data = '0;
    logic [4:0]  host_addr = '0;
    logic        host_last = 1'b0;
    logic        host_val = 1'b0, host_val0 = 1'b0;
    logic        layer_busy = 1'b0, layer_busy0 = 1'b0;

    logic        host_rdy, cfg_valid, cfg_done;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic [3:0]  fifo_count;
    logic        rdy0, valid0, done0;
    logic [31:0] data0;
    logic [4:0]  addr0;
    logic [3:0]  count0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [4:0]  pa[$], pa0[$];
    logic [31:0] pd[$];
    int          pc[$], pc0[$], dc[$], dc0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cfg_writer #(.CFG_DWIDTH(32), .CFG_AWIDTH(5), .FIFO_DEPTH(8), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .host_data(host_data), .host_addr(host_addr),
        .host_last(host_last), .host_val(host_val), .host_rdy(host_rdy),
        .layer_busy(layer_busy), .cfg_data(cfg_data), .cfg_addr(cfg_addr),
        .cfg_valid(cfg_valid), .cfg_done(cfg_done), .fifo_count(fifo_count)
    );

    cfg_writer #(.CFG_DWIDTH(32), .CFG_AWIDTH(5), .FIFO_DEPTH(8), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .host_data(host_data), .host_addr(host_addr),
        .host_last(host_last), .host_val(host_val0), .host_rdy(rdy0),
        .layer_busy(layer_busy0), .cfg_data(data0), .cfg_addr(addr0),
        .cfg_valid(valid0), .cfg_done(done0), .fifo_count(count0)
    );

    // Pulse log, sampled mid-cycle and stamped with the edge that produced it.
    always @(negedge clk) begin
        if (cfg_valid) begin
            pa.push_back(cfg_addr);
            pd.push_back(cfg_data);
            pc.push_back(cyc);
        end
        if (cfg_done) dc.push_back(cyc);
        if (valid0) begin
            pa0.push_back(addr0);
            pc0.push_back(cyc);
        end
        if (done0) dc0.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        pa.delete(); pd.delete(); pc.delete(); dc.delete();
        pa0.delete(); pc0.delete(); dc0.delete();
    endtask

    task automatic push(input bit sel, input logic [4:0] a, input logic [31:0] d, input logic l);
        host_addr = a;
        host_data = d;
        host_last = l;
        if (sel) host_val0 = 1'b1;
        else     host_val  = 1'b1;
        for (int i = 0; i < 200 && !(sel ? rdy0 : host_rdy); i++) step(1);
        check("push_rdy", sel ? rdy0 : host_rdy, 1);
        step(1);
        host_val  = 1'b0;
        host_val0 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, cfg_valid, 0);
        check({tag, "_done"},  cfg_done, 0);
        check({tag, "_data"},  cfg_data, 0);
        check({tag, "_addr"},  cfg_addr, 0);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_rdy"},   host_rdy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, tb, tp, nv;

        // Reset values and release.
        rst = 1'b1;
        step(2);
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        check("rst_rdy_release", host_rdy, 1);
        check("rst_rdy0_release", rdy0, 1);

        // Three-write batch with one idle cycle between strobes.
        clear_log();
        push(0, 5'd1, 32'h11, 1'b0);
        t0 = cyc;
        push(0, 5'd2, 32'h22, 1'b0);
        push(0, 5'd3, 32'h33, 1'b1);
        step(12);
        check("t1_npulse", pa.size(), 3);
        if (pa.size() == 3) begin
            check("t1_a0", pa[0], 1);  check("t1_d0", pd[0], 32'h11);
            check("t1_a1", pa[1], 2);  check("t1_d1", pd[1], 32'h22);
            check("t1_a2", pa[2], 3);  check("t1_d2", pd[2], 32'h33);
            check("t1_latency", pc[0], t0 + 1);
            check("t1_space01", pc[1] - pc[0], 2);
            check("t1_space12", pc[2] - pc[1], 2);
            check("t1_hold_addr", cfg_addr, 3);
        end
        check("t1_ndone", dc.size(), 1);
        if (dc.size() == 1 && pc.size() == 3) check("t1_done_cyc", dc[0], pc[2] + 1);
        check("t1_count", fifo_count, 0);

        // Batch held off while the datapath is busy.
        clear_log();
        layer_busy = 1'b1;
        push(0, 5'd4, 32'h44, 1'b0);
        push(0, 5'd5, 32'h55, 1'b1);
        step(8);
        check("t2_held", pa.size(), 0);
        check("t2_count", fifo_count, 2);
        layer_busy = 1'b0;
        tb = cyc;
        step(8);
        check("t2_npulse", pa.size(), 2);
        if (pa.size() == 2) begin
            check("t2_first", pc[0], tb + 1);
            check("t2_second", pc[1], tb + 3);
            check("t2_a1", pa[1], 5);
            check("t2_d1", pd[1], 32'h55);
        end
        check("t2_ndone", dc.size(), 1);
        if (dc.size() == 1) check("t2_done_cyc", dc[0], tb + 4);

        // Mid-batch stall ignores layer_busy.
        clear_log();
        push(0, 5'd6, 32'h66, 1'b0);
        step(1);
        layer_busy = 1'b1;
        step(4);
        check("t3_state_stall", dut.state_q, ST_STALL);
        check("t3_one_pulse", pa.size(), 1);
        push(0, 5'd7, 32'h77, 1'b1);
        tp = cyc;
        step(6);
        check("t3_npulse", pa.size(), 2);
        if (pa.size() == 2) begin
            check("t3_a1", pa[1], 7);
            check("t3_d1", pd[1], 32'h77);
            check("t3_cyc", pc[1], tp + 1);
        end
        check("t3_ndone", dc.size(), 1);
        if (dc.size() == 1) check("t3_done_cyc", dc[0], tp + 2);
        layer_busy = 1'b0;

        // Fill to capacity, hold off the ninth write, then drain all ten.
        clear_log();
        layer_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(0, 5'(10 + i), 32'h100 + i, 1'b0);
        check("t4_full_rdy", host_rdy, 0);
        check("t4_full_count", fifo_count, 8);
        host_addr = 5'd18;
        host_data = 32'h108;
        host_last = 1'b0;
        host_val  = 1'b1;
        step(3);
        check("t4_holdoff_count", fifo_count, 8);
        check("t4_holdoff_pulse", pa.size(), 0);
        host_val   = 1'b0;
        layer_busy = 1'b0;
        push(0, 5'd18, 32'h108, 1'b0);
        push(0, 5'd19, 32'h109, 1'b1);
        step(30);
        check("t4_npulse", pa.size(), 10);
        if (pa.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                check("t4_addr", pa[i], 10 + i);
                check("t4_data", pd[i], 32'h100 + i);
            end
        end
        check("t4_ndone", dc.size(), 1);
        check("t4_count", fifo_count, 0);

        // Back-to-back strobes with no gap.
        clear_log();
        layer_busy0 = 1'b1;
        for (int i = 0; i < 4; i++) push(1, 5'(24 + i), 32'h200 + i, i == 3);
        layer_busy0 = 1'b0;
        tb = cyc;
        step(10);
        check("t5_npulse", pa0.size(), 4);
        if (pa0.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t5_cyc", pc0[i], tb + 1 + i);
                check("t5_addr", pa0[i], 24 + i);
            end
        end
        check("t5_ndone", dc0.size(), 1);
        if (dc0.size() == 1) check("t5_done_cyc", dc0[0], tb + 5);

        // Reset after two of four writes abandons the batch.
        clear_log();
        layer_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(0, 5'(20 + i), 32'h300 + i, i == 3);
        layer_busy = 1'b0;
        nv = 0;
        for (int i = 0; i < 50 && nv < 2; i++) begin
            step(1);
            if (cfg_valid) nv++;
        end
        check("t6_two_issued", nv, 2);
        rst = 1'b1;
        step(1);
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        step(10);
        check("t6_no_done", dc.size(), 0);
        check("t6_no_more", pa.size(), 2);
        check("t6_count", fifo_count, 0);
        push(0, 5'd9, 32'h99, 1'b1);
        step(6);
        check("t6_npulse", pa.size(), 3);
        if (pa.size() == 3) begin
            check("t6_addr", pa[2], 9);
            check("t6_data", pd[2], 32'h99);
        end
        check("t6_ndone", dc.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
